// File: rtl/machine_timer.sv
// RISC-V machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, CTRL.EN, and a
// shadowed mtime high word so a LO-then-HI read pair is atomic.
module machine_timer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        timer_irq
);

  localparam logic [15:0] PrescLast = 16'(PRESCALE - 1);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic [15:0] presc_q, presc_d;
  logic        en_q, en_d;
  logic        irq_d;

  logic       in_window, aligned, valid, acc_rd, acc_wr;
  logic [2:0] word;

  assign in_window = (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign aligned   = (bus_addr[1:0] == 2'b00);
  assign word      = bus_addr[4:2];
  assign valid     = in_window & aligned & (word <= 3'd4);
  assign acc_rd    = bus_sel & ~bus_we & valid;
  assign acc_wr    = bus_sel & bus_we & valid;
  assign bus_err   = bus_sel & ~valid;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] mask);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    presc_d     = presc_q;
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    en_d        = en_q;
    shadow_hi_d = shadow_hi_q;
    irq_d       = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      if (presc_q >= PrescLast) begin
        presc_d = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    if (acc_wr) begin
      unique case (word)
        3'd0: begin
          // Software write wins over the increment and restarts the prescaler.
          mtime_d        = mtime_q;
          mtime_d[31:0]  = merge(mtime_q[31:0], bus_wdata, bus_wmask);
          presc_d        = '0;
        end
        3'd1: begin
          mtime_d        = mtime_q;
          mtime_d[63:32] = merge(mtime_q[63:32], bus_wdata, bus_wmask);
          presc_d        = '0;
        end
        3'd2: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], bus_wdata, bus_wmask);
        3'd3: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], bus_wdata, bus_wmask);
        3'd4: if (bus_wmask[0]) en_d = bus_wdata[0];
        default: ;
      endcase
    end

    if (acc_rd && word == 3'd0) shadow_hi_d = mtime_q[63:32];
  end

  always_comb begin
    bus_rdata = '0;
    if (acc_rd) begin
      unique case (word)
        3'd0:    bus_rdata = mtime_q[31:0];
        3'd1:    bus_rdata = shadow_hi_q;
        3'd2:    bus_rdata = mtimecmp_q[31:0];
        3'd3:    bus_rdata = mtimecmp_q[63:32];
        3'd4:    bus_rdata = {31'd0, en_q};
        default: bus_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      shadow_hi_q <= '0;
      presc_q     <= '0;
      en_q        <= 1'b0;
      timer_irq   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      shadow_hi_q <= shadow_hi_d;
      presc_q     <= presc_d;
      en_q        <= en_d;
      timer_irq   <= irq_d;
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: one instance with PRESCALE=1 and one with
// PRESCALE=4 share the bus; each access is one cycle, driven after negedge.
module tb_machine_timer;

  localparam logic [31:0] Base = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel1 = 1'b0, sel4 = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] rdata1, rdata4;
  logic        err1, err4, irq1, irq4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  machine_timer #(.PRESCALE(1), .BASE_ADDR(Base)) dut (
    .clk(clk), .rst(rst), .bus_sel(sel1), .bus_we(we), .bus_addr(addr),
    .bus_wdata(wdata), .bus_wmask(wmask), .bus_rdata(rdata1), .bus_err(err1),
    .timer_irq(irq1)
  );

  machine_timer #(.PRESCALE(4), .BASE_ADDR(Base)) dut4 (
    .clk(clk), .rst(rst), .bus_sel(sel4), .bus_we(we), .bus_addr(addr),
    .bus_wdata(wdata), .bus_wmask(wmask), .bus_rdata(rdata4), .bus_err(err4),
    .timer_irq(irq4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle; returns combinational outputs sampled before the access edge.
  task automatic access(input bit use4, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    sel1 = ~use4; sel4 = use4; we = w; addr = a; wdata = d; wmask = m;
    #1;
    rd = use4 ? rdata4 : rdata1;
    er = use4 ? err4 : err1;
    @(posedge clk);
    #1;
    sel1 = 1'b0; sel4 = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input bit use4, input logic [5:0] off, input logic [31:0] d,
                    input logic [3:0] m);
    logic [31:0] rd;
    logic        er;
    access(use4, Base + 32'(off), 1'b1, d, m, rd, er);
  endtask

  task automatic rd_chk(input bit use4, input logic [5:0] off, input string name,
                        input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    access(use4, Base + 32'(off), 1'b0, 32'd0, 4'd0, rd, er);
    check(name, rd, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rd;
    logic        er;

    vecs[0] = '{"rst_mtime_lo",   Base + 32'h00, 1'b0, 32'h0, 32'h0,         1'b0};
    vecs[1] = '{"rst_mtime_hi",   Base + 32'h04, 1'b0, 32'h0, 32'h0,         1'b0};
    vecs[2] = '{"rst_cmp_lo",     Base + 32'h08, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[3] = '{"rst_cmp_hi",     Base + 32'h0C, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[4] = '{"rst_ctrl",       Base + 32'h10, 1'b0, 32'h0, 32'h0,         1'b0};
    vecs[5] = '{"bad_off_14",     Base + 32'h14, 1'b0, 32'h0, 32'h0,         1'b1};
    vecs[6] = '{"bad_wr_1c",      Base + 32'h1C, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[7] = '{"unaligned",      Base + 32'h02, 1'b0, 32'h0, 32'h0,         1'b1};
    vecs[8] = '{"out_of_window",  Base + 32'h20, 1'b1, 32'h1, 32'h0,         1'b1};
    vecs[9] = '{"ctrl_unchanged", Base + 32'h10, 1'b0, 32'h0, 32'h0,         1'b0};

    #22 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_irq", irq1, 1'b0);

    // Reset state and address decode
    for (int i = 0; i < 10; i++) begin
      access(1'b0, vecs[i].addr, vecs[i].we, vecs[i].wdata, 4'hF, rd, er);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, er, vecs[i].exp_err);
    end

    // PRESCALE=4: 40 cycles -> 10 ticks, then hold with EN=0
    wr(1'b1, 6'h10, 32'h1, 4'hF);
    repeat (40) @(posedge clk);
    rd_chk(1'b1, 6'h00, "presc4_count", 32'd10);
    wr(1'b1, 6'h10, 32'h0, 4'hF);
    repeat (20) @(posedge clk);
    rd_chk(1'b1, 6'h00, "presc4_hold", 32'd10);

    // Masked MTIME_LO write during counting restarts the prescaler (held at 2)
    wr(1'b1, 6'h10, 32'h1, 4'hF);
    wr(1'b1, 6'h00, 32'h0000_AB00, 4'b0010);
    rd_chk(1'b1, 6'h00, "presc4_mask_wr", 32'h0000_AB0A);
    @(posedge clk);
    rd_chk(1'b1, 6'h00, "presc4_restart", 32'h0000_AB0A);
    @(posedge clk);
    rd_chk(1'b1, 6'h00, "presc4_next_tick", 32'h0000_AB0B);

    // Compare: irq one cycle after mtime==20
    wr(1'b0, 6'h0C, 32'h0, 4'hF);
    wr(1'b0, 6'h08, 32'd20, 4'hF);
    wr(1'b0, 6'h10, 32'h1, 4'hF);
    repeat (20) @(posedge clk);
    #1 check("irq_at_eq", irq1, 1'b0);
    @(posedge clk);
    #1 check("irq_after_eq", irq1, 1'b1);
    wr(1'b0, 6'h08, 32'd1000, 4'hF);
    check("irq_cmp_write_edge", irq1, 1'b1);
    @(posedge clk);
    #1 check("irq_cleared", irq1, 1'b0);

    // Atomic 64-bit read across a carry
    wr(1'b0, 6'h10, 32'h0, 4'hF);
    wr(1'b0, 6'h04, 32'h0, 4'hF);
    wr(1'b0, 6'h00, 32'hFFFF_FFFE, 4'hF);
    wr(1'b0, 6'h10, 32'h1, 4'hF);
    @(posedge clk);
    rd_chk(1'b0, 6'h00, "carry_lo", 32'hFFFF_FFFF);
    rd_chk(1'b0, 6'h04, "carry_shadow_hi", 32'h0);
    rd_chk(1'b0, 6'h00, "fresh_lo", 32'h1);
    rd_chk(1'b0, 6'h04, "fresh_hi", 32'h1);

    // Byte-masked MTIME_LO write wins over the increment
    wr(1'b0, 6'h10, 32'h0, 4'hF);
    wr(1'b0, 6'h00, 32'h1234_5678, 4'hF);
    wr(1'b0, 6'h10, 32'h1, 4'hF);
    wr(1'b0, 6'h00, 32'h0000_AB00, 4'b0010);
    rd_chk(1'b0, 6'h00, "mask_wr_no_inc", 32'h1234_AB78);
    rd_chk(1'b0, 6'h00, "mask_wr_then_inc", 32'h1234_AB79);

    // Async reset mid-count with irq high
    repeat (2) @(posedge clk);
    #1 check("irq_before_rst", irq1, 1'b1);
    #1 rst = 1'b1;
    sel1 = 1'b1; we = 1'b0; addr = Base + 32'h00;
    #1 check("rst_async_irq", irq1, 1'b0);
    check("rst_async_mtime", rdata1, 32'h0);
    addr = Base + 32'h10;
    #1 check("rst_async_ctrl", rdata1, 32'h0);
    sel1 = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    rd_chk(1'b0, 6'h00, "post_rst_hold", 32'h0);
    rd_chk(1'b0, 6'h10, "post_rst_ctrl", 32'h0);
    rd_chk(1'b1, 6'h00, "post_rst_presc4", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
